// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode-side bus between the decode stage and the forwarding/hazard unit
interface fwd_hazard_unit_if #(
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int FWD_DEPTH    = 3,
  parameter int CNT_W        = 16
);
  logic                         id_valid;
  logic                         id_wr_en;
  logic [4:0]                   id_rd;
  logic                         id_is_load;
  logic [NUM_RD_PORTS-1:0]      id_rs_used;
  logic [5*NUM_RD_PORTS-1:0]    id_rs_sel;
  logic [XLEN*NUM_RD_PORTS-1:0] id_rs_val;
  logic [XLEN*FWD_DEPTH-1:0]    stage_val;
  logic                         flush;
  logic [XLEN*NUM_RD_PORTS-1:0] fwd_val;
  logic [NUM_RD_PORTS-1:0]      fwd_hit;
  logic                         stall;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output id_valid, id_wr_en, id_rd, id_is_load, id_rs_used, id_rs_sel, id_rs_val, stage_val, flush,
    input  fwd_val, fwd_hit, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_wr_en, id_rd, id_is_load, id_rs_used, id_rs_sel, id_rs_val, stage_val, flush,
    output fwd_val, fwd_hit, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use stall and stall counter between decode and execute
module fwd_hazard_unit #(
  parameter int XLEN           = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int FWD_DEPTH      = 3,
  parameter int LOAD_RDY_STAGE = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  sb_entry_t                    sb [FWD_DEPTH];
  sb_entry_t                    id_entry;
  logic [CNT_W-1:0]             stall_cnt_q;
  logic [XLEN*NUM_RD_PORTS-1:0] fwd_val_c;
  logic [NUM_RD_PORTS-1:0]      hit_c;
  logic [NUM_RD_PORTS-1:0]      nrdy_c;
  logic [4:0]                   sel_p;
  logic                         stall_c;

  assign id_entry = {bus.id_wr_en & (bus.id_rd != 5'd0), bus.id_rd, bus.id_is_load};

  // Oldest-to-youngest scan so the youngest matching stage is the last writer.
  always_comb begin
    fwd_val_c = bus.id_rs_val;
    hit_c     = '0;
    nrdy_c    = '0;
    sel_p     = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      sel_p = bus.id_rs_sel[5*p +: 5];
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (sb[k].vld && (sb[k].rd == sel_p) && (sel_p != 5'd0)) begin
          fwd_val_c[XLEN*p +: XLEN] = bus.stage_val[XLEN*k +: XLEN];
          hit_c[p]                  = 1'b1;
          nrdy_c[p]                 = sb[k].ld && (k < LOAD_RDY_STAGE);
        end
      end
    end
  end

  assign stall_c = bus.id_valid & ~bus.flush & (|(bus.id_rs_used & nrdy_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        sb[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
      sb[0] <= (bus.id_valid & ~stall_c & ~bus.flush) ? id_entry : '0;
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_val   = fwd_val_c;
  assign bus.fwd_hit   = hit_c;
  assign bus.stall     = stall_c;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit with a history-based reference model
module tb_fwd_hazard_unit;

  localparam int XLEN = 32;
  localparam int NP   = 2;
  localparam int FD   = 3;
  localparam int LRS  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            id_valid, id_wr_en, id_is_load, flush;
  logic [4:0]      id_rd;
  logic [NP-1:0]   id_rs_used;
  logic [4:0]      sel [NP];
  logic [XLEN-1:0] rs_val [NP];
  logic [XLEN-1:0] sv [FD];

  fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .FWD_DEPTH(FD), .CNT_W(16)) if0 ();
  fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .FWD_DEPTH(FD), .CNT_W(2))  if1 ();

  assign if0.id_valid   = id_valid;    assign if1.id_valid   = id_valid;
  assign if0.id_wr_en   = id_wr_en;    assign if1.id_wr_en   = id_wr_en;
  assign if0.id_rd      = id_rd;       assign if1.id_rd      = id_rd;
  assign if0.id_is_load = id_is_load;  assign if1.id_is_load = id_is_load;
  assign if0.id_rs_used = id_rs_used;  assign if1.id_rs_used = id_rs_used;
  assign if0.flush      = flush;       assign if1.flush      = flush;
  assign if0.id_rs_sel  = {sel[1], sel[0]};
  assign if1.id_rs_sel  = {sel[1], sel[0]};
  assign if0.id_rs_val  = {rs_val[1], rs_val[0]};
  assign if1.id_rs_val  = {rs_val[1], rs_val[0]};
  assign if0.stage_val  = {sv[2], sv[1], sv[0]};
  assign if1.stage_val  = {sv[2], sv[1], sv[0]};

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .FWD_DEPTH(FD), .LOAD_RDY_STAGE(LRS), .CNT_W(16)) u0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  fwd_hazard_unit #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .FWD_DEPTH(FD), .LOAD_RDY_STAGE(LRS), .CNT_W(2)) u1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what decode issued in the last FD cycles, youngest first.
  typedef struct {
    bit       wr;
    bit [4:0] rd;
    bit       ld;
  } issued_t;
  issued_t hist[$];

  logic [XLEN-1:0] exp_val [NP];
  logic [NP-1:0]   exp_hit;
  logic            exp_stall;
  logic [15:0]     exp_cnt0;
  int              exp_cnt1;

  function automatic void model_reset();
    issued_t none;
    none = '{wr: 1'b0, rd: 5'd0, ld: 1'b0};
    hist.delete();
    for (int i = 0; i < FD; i++) hist.push_back(none);
    exp_cnt0 = 16'd0;
    exp_cnt1 = 0;
  endfunction

  function automatic void model_eval();
    bit blocked;
    blocked = 1'b0;
    for (int p = 0; p < NP; p++) begin
      bit found;
      found      = 1'b0;
      exp_val[p] = rs_val[p];
      exp_hit[p] = 1'b0;
      for (int age = 0; age < FD; age++) begin
        if (!found && sel[p] != 5'd0 && hist[age].wr && hist[age].rd == sel[p]) begin
          found      = 1'b1;
          exp_val[p] = sv[age];
          exp_hit[p] = 1'b1;
          if (id_rs_used[p] && hist[age].ld && age < LRS) blocked = 1'b1;
        end
      end
    end
    exp_stall = id_valid && !flush && blocked;
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    issued_t e;
    model_eval();
    e = '{wr: 1'b0, rd: 5'd0, ld: 1'b0};
    if (id_valid && !exp_stall && !flush)
      e = '{wr: id_wr_en && (id_rd != 5'd0), rd: id_rd, ld: id_is_load};
    hist.push_front(e);
    void'(hist.pop_back());
    if (exp_stall) begin
      if (exp_cnt0 != 16'hFFFF) exp_cnt0 = exp_cnt0 + 16'd1;
      if (exp_cnt1 < 3) exp_cnt1 = exp_cnt1 + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic ld,
                       input logic [NP-1:0] used, input logic [4:0] s0, input logic [4:0] s1);
    id_valid = v; id_wr_en = wr; id_rd = rd; id_is_load = ld;
    id_rs_used = used; sel[0] = s0; sel[1] = s1; flush = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b11, 5'd3, 5'd4);
    rs_val[0] = 32'h11; rs_val[1] = 32'h22;
    for (int k = 0; k < FD; k++) sv[k] = 32'hC0DE_0000 + k;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    settle();
    checks++; if (if0.fwd_val !== {32'h22, 32'h11}) begin errors++; $display("FAIL reset_fwd_val got %h want %h", if0.fwd_val, {32'h22, 32'h11}); end
    checks++; if (if0.fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit got %b want 00", if0.fwd_hit); end
    checks++; if (if0.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", if0.stall); end
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", if0.stall_cnt); end
  endtask

  task automatic test_forward();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd1);
    sv[0] = 32'hDEAD; sv[1] = 32'h1; sv[2] = 32'h2;
    settle();
    checks++; if (if0.fwd_val[31:0] !== 32'hDEAD || if0.fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL fwd_ex got %h/%b want dead/1", if0.fwd_val[31:0], if0.fwd_hit[0]); end
    checks++; if (if0.stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall got %b want 0", if0.stall); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd0);
    sv[0] = 32'h3; sv[1] = 32'h4; sv[2] = 32'hDEAD;
    settle();
    checks++; if (if0.fwd_val[31:0] !== 32'hDEAD || if0.fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL fwd_wb got %h/%b want dead/1", if0.fwd_val[31:0], if0.fwd_hit[0]); end
    tick();
  endtask

  task automatic test_youngest_wins();
    drive(1'b1, 1'b1, 5'd6, 1'b0, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b10, 5'd0, 5'd6);
    sv[0] = 32'hBBBB; sv[1] = 32'hAAAA; sv[2] = 32'h5;
    settle();
    checks++; if (if0.fwd_val[63:32] !== 32'hBBBB || if0.fwd_hit !== 2'b10) begin errors++; $display("FAIL youngest got %h/%b want bbbb/10", if0.fwd_val[63:32], if0.fwd_hit); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b10, 5'd0, 5'd7);
    sv[0] = 32'h9999; sv[1] = 32'h8888; sv[2] = 32'h7777;
    settle();
    checks++; if (if0.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", if0.stall); end
    tick();
    sv[0] = 32'h5555; sv[1] = 32'h1234;
    settle();
    checks++; if (if0.stall !== 1'b0) begin errors++; $display("FAIL load_use_release got %b want 0", if0.stall); end
    checks++; if (if0.fwd_val[63:32] !== 32'h1234) begin errors++; $display("FAIL load_use_fwd got %h want 1234", if0.fwd_val[63:32]); end
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", if0.stall_cnt); end
    tick();
  endtask

  task automatic test_flush_and_x0();
    drive(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7, 5'd0);
    flush = 1'b1;
    settle();
    checks++; if (if0.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", if0.stall); end
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    settle();
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", if0.stall_cnt); end
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd0, 5'd0);
    rs_val[0] = 32'h0;
    settle();
    checks++; if (if0.fwd_hit[0] !== 1'b0 || if0.fwd_val[31:0] !== 32'h0) begin errors++; $display("FAIL x0_fwd got %h/%b want 0/0", if0.fwd_val[31:0], if0.fwd_hit[0]); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NP; p++) rs_val[p] = $urandom;
      for (int k = 0; k < FD; k++) sv[k] = $urandom;
      settle();
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (if0.fwd_val[XLEN*p +: XLEN] !== exp_val[p]) begin
          errors++; $display("FAIL rand_fwd_val[%0d] cyc %0d got %h want %h", p, n, if0.fwd_val[XLEN*p +: XLEN], exp_val[p]);
        end
      end
      checks++; if (if0.fwd_hit !== exp_hit) begin errors++; $display("FAIL rand_fwd_hit cyc %0d got %b want %b", n, if0.fwd_hit, exp_hit); end
      checks++; if (if0.stall !== exp_stall) begin errors++; $display("FAIL rand_stall cyc %0d got %b want %b", n, if0.stall, exp_stall); end
      checks++; if (if0.stall_cnt !== exp_cnt0) begin errors++; $display("FAIL rand_cnt16 cyc %0d got %0d want %0d", n, if0.stall_cnt, exp_cnt0); end
      checks++; if (int'(if1.stall_cnt) != exp_cnt1) begin errors++; $display("FAIL rand_cnt2 cyc %0d got %0d want %0d", n, if1.stall_cnt, exp_cnt1); end
      tick();
    end
  endtask

  task automatic test_saturation_and_reset();
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 5'd0);
      settle(); tick();
      drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd9, 5'd0);
      settle();
      checks++; if (if1.stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d] got %b want 1", i, if1.stall); end
      tick();
    end
    checks++; if (if1.stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", if1.stall_cnt); end
    checks++; if (if0.stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d want 5", if0.stall_cnt); end
    drive(1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 2'b01, 5'd9, 5'd0);
    settle();
    checks++; if (if1.stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b want 1", if1.stall); end
    rst = 1'b1;
    #1;
    checks++; if (if0.stall !== 1'b0 || if1.stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b/%b want 0/0", if0.stall, if1.stall); end
    checks++; if (if0.stall_cnt !== 16'd0 || if1.stall_cnt !== 2'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", if0.stall_cnt, if1.stall_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    for (int p = 0; p < NP; p++) rs_val[p] = '0;
    for (int k = 0; k < FD; k++) sv[k] = '0;
    model_reset();
    test_reset();
    test_forward();
    test_youngest_wins();
    test_load_use();
    test_flush_and_x0();
    test_random();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
